// File: rtl/pipe_adder_pkg.sv
// Shared arithmetic constants and elaboration helpers for the sliced pipelined adder.
package pipe_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_fa_cell.sv
// One-bit full adder cell; chained SLICE times per pipeline stage.
module fa_cell
  import pipe_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one WIDTH/STAGES-bit ripple slice per stage, carry
// registered between stages, valid/ready handshake with bubble collapsing.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF
);

  localparam int SLICE = slice_w(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] vld_d, vld_q;
  logic [STAGES-1:0] vin, adv, ld, take;
  logic              in_rdy, in_fire;

  // Stage k's source: A bits above slice k with finished sum bits below it,
  // conditioned B bits above slice k, and the carry into slice k.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [STAGES-1:0] src_c;

  assign src_a[0] = A;
  assign src_b[0] = (SUB == MODE_ADD) ? B : ~B;
  assign src_c[0] = (SUB == MODE_SUB) ? 1'b1 : CIN;

  always_comb begin
    adv             = '0;
    ld              = '0;
    take            = '0;
    vld_d           = vld_q;
    adv[STAGES-1]   = OUT_READY;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld_q[k+1] || adv[k+1];
    end
    in_rdy  = !RST && (!vld_q[0] || adv[0]);
    in_fire = IN_VALID && in_rdy;
    vin     = (vld_q << 1) | STAGES'(in_fire);
    for (int k = 0; k < STAGES; k++) begin
      ld[k]   = !vld_q[k] || adv[k];
      take[k] = ld[k] && vin[k];
      if (ld[k]) vld_d[k] = vin[k];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign IN_READY  = in_rdy;
  assign OUT_VALID = vld_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int HI = LO + SLICE;

    logic [SLICE:0]   c;
    logic [SLICE-1:0] s;
    logic [WIDTH-1:0] acc_d, acc_q;
    logic             co_d, co_q;

    assign c[0] = src_c[k];

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
      fa_cell u_fa (
        .x  (src_a[k][LO+i]),
        .y  (src_b[k][LO+i]),
        .ci (c[i]),
        .s  (s[i]),
        .co (c[i+1])
      );
    end

    always_comb begin
      acc_d = acc_q;
      co_d  = co_q;
      if (take[k]) begin
        acc_d            = src_a[k];
        acc_d[LO+:SLICE] = s;
        co_d             = c[SLICE];
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        acc_q <= '0;
        co_q  <= 1'b0;
      end else begin
        acc_q <= acc_d;
        co_q  <= co_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] b_d, b_q;

      always_comb begin
        b_d = b_q;
        if (take[k]) b_d = src_b[k][WIDTH-1:HI];
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) b_q <= '0;
        else     b_q <= b_d;
      end

      assign src_a[k+1] = acc_q;
      assign src_b[k+1] = {b_q, {HI{1'b0}}};
      assign src_c[k+1] = co_q;
    end else begin : g_out
      logic ovf_d, ovf_q;

      // Carry into the MSB lives inside this last slice.
      always_comb begin
        ovf_d = ovf_q;
        if (take[k]) ovf_d = c[SLICE] ^ c[SLICE-1];
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end

      assign SUM  = acc_q;
      assign COUT = co_q;
      assign OVF  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed arithmetic/handshake scenarios on (8,2) and
// random valid/ready regression on (8,1), (8,8) and (32,4) against a reference model.
module tb_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iv, orr, ci, sb;
  logic [31:0] a_v [4];
  logic [31:0] b_v [4];
  wire  [3:0]  ir, ov, co, of;
  wire  [7:0]  sum0, sum1, sum2;
  wire  [31:0] sum3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[0]), .IN_READY(ir[0]),
    .A(a_v[0][7:0]), .B(b_v[0][7:0]), .CIN(ci[0]), .SUB(sb[0]),
    .OUT_VALID(ov[0]), .OUT_READY(orr[0]), .SUM(sum0), .COUT(co[0]), .OVF(of[0]));

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[1]), .IN_READY(ir[1]),
    .A(a_v[1][7:0]), .B(b_v[1][7:0]), .CIN(ci[1]), .SUB(sb[1]),
    .OUT_VALID(ov[1]), .OUT_READY(orr[1]), .SUM(sum1), .COUT(co[1]), .OVF(of[1]));

  pipe_adder #(.WIDTH(8), .STAGES(8)) u_dut2 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[2]), .IN_READY(ir[2]),
    .A(a_v[2][7:0]), .B(b_v[2][7:0]), .CIN(ci[2]), .SUB(sb[2]),
    .OUT_VALID(ov[2]), .OUT_READY(orr[2]), .SUM(sum2), .COUT(co[2]), .OVF(of[2]));

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut3 (
    .CLK(clk), .RST(rst), .IN_VALID(iv[3]), .IN_READY(ir[3]),
    .A(a_v[3]), .B(b_v[3]), .CIN(ci[3]), .SUB(sb[3]),
    .OUT_VALID(ov[3]), .OUT_READY(orr[3]), .SUM(sum3), .COUT(co[3]), .OVF(of[3]));

  function automatic logic [31:0] sum_of(input int d);
    case (d)
      0:       return {24'h0, sum0};
      1:       return {24'h0, sum1};
      2:       return {24'h0, sum2};
      default: return sum3;
    endcase
  endfunction

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                            input logic c, input logic s);
    longint p, ua, ub, sa, sbv, r, sr;
    logic [63:0] rr;
    logic cout, ovf;
    p   = longint'(1) << w;
    ua  = longint'({32'h0, aa}) & (p - 1);
    ub  = longint'({32'h0, bb}) & (p - 1);
    sa  = (ua >= p / 2) ? ua - p : ua;
    sbv = (ub >= p / 2) ? ub - p : ub;
    if (!s) begin
      r    = ua + ub + longint'({63'h0, c});
      sr   = sa + sbv + longint'({63'h0, c});
      cout = (r >= p);
    end else begin
      r    = ua - ub;
      sr   = sa - sbv;
      cout = (ua >= ub);
    end
    ovf = (sr >= p / 2) || (sr < -(p / 2));
    rr  = 64'(r & (p - 1));
    return {ovf, cout, rr[31:0]};
  endfunction

  task automatic drive_single(input logic [7:0] aa, input logic [7:0] bb, input logic c, input logic s,
                              output logic [7:0] sum_o, output logic co_o, output logic ov_o,
                              output int lat);
    @(negedge clk);
    orr[0] = 1'b1; iv[0] = 1'b1;
    a_v[0] = {24'h0, aa}; b_v[0] = {24'h0, bb}; ci[0] = c; sb[0] = s;
    @(negedge clk);
    iv[0] = 1'b0; a_v[0] = $urandom; b_v[0] = $urandom;
    ci[0] = 1'($urandom_range(0, 1)); sb[0] = 1'($urandom_range(0, 1));
    lat = 1;
    while (ov[0] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sum_o = sum0; co_o = co[0]; ov_o = of[0];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({ov[d], co[d], of[d], ir[d]} !== 4'b0000 || sum_of(d) !== 32'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d: valid/cout/ovf/ready=%b%b%b%b sum=%h, required 0000 sum=0",
                 d, ov[d], co[d], of[d], ir[d], sum_of(d));
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
        errors++;
        $display("FAIL after_reset dut%0d: ready=%b valid=%b, required ready=1 valid=0", d, ir[d], ov[d]);
      end
    end
  endtask

  task automatic test_add;
    logic [7:0] s; logic c, o; int lat;
    drive_single(8'h7F, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_signed_ovf: sum=%h cout=%b ovf=%b, required sum=80 cout=0 ovf=1", s, c, o);
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency: %0d cycles, required 2", lat);
    end
    drive_single(8'hFF, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap: sum=%h cout=%b ovf=%b, required sum=00 cout=1 ovf=0", s, c, o);
    end
    drive_single(8'hFF, 8'h01, 1'b1, 1'b0, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap_cin: sum=%h cout=%b ovf=%b, required sum=01 cout=1 ovf=0", s, c, o);
    end
  endtask

  task automatic test_sub;
    logic [7:0] s; logic c, o; int lat;
    drive_single(8'h00, 8'h01, 1'b1, 1'b1, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, required sum=FF cout=0 ovf=0", s, c, o);
    end
    drive_single(8'h80, 8'h01, 1'b0, 1'b1, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_signed_ovf: sum=%h cout=%b ovf=%b, required sum=7F cout=1 ovf=1", s, c, o);
    end
  endtask

  task automatic test_back_pressure;
    int idx, low_cnt, got_n, cyc;
    logic [7:0] got [5];
    int when [5];
    idx = 0; low_cnt = 0; got_n = 0; cyc = 0;
    @(negedge clk);
    orr[0] = 1'b0; iv[0] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checks++;
        if (ov[0] !== 1'b1 || sum0 !== 8'h11) begin
          errors++;
          $display("FAIL stall_hold cycle %0d: valid=%b sum=%h, required valid=1 sum=11", c, ov[0], sum0);
        end
      end
      if (idx < 5) begin
        iv[0] = 1'b1; a_v[0] = 32'(idx + 1); b_v[0] = 32'h10; ci[0] = 1'b0; sb[0] = 1'b0;
      end
      #1;
      if (iv[0] && ir[0]) idx++;
      else if (iv[0]) low_cnt++;
    end
    checks++;
    if (idx !== 2 || low_cnt !== 4) begin
      errors++;
      $display("FAIL stall_accepts: accepted=%0d refused=%0d, required accepted=2 refused=4", idx, low_cnt);
    end
    while (got_n < 5 && cyc < 30) begin
      @(negedge clk);
      if (idx < 5) begin
        iv[0] = 1'b1; a_v[0] = 32'(idx + 1); b_v[0] = 32'h10; ci[0] = 1'b0; sb[0] = 1'b0;
      end else begin
        iv[0] = 1'b0;
      end
      orr[0] = 1'b1;
      #1;
      if (iv[0] && ir[0]) idx++;
      if (ov[0]) begin
        got[got_n] = sum0; when[got_n] = cyc; got_n++;
      end
      cyc++;
    end
    iv[0] = 1'b0;
    checks++;
    if (got_n !== 5) begin
      errors++;
      $display("FAIL drain_count: %0d results, required 5", got_n);
    end
    for (int i = 0; i < got_n; i++) begin
      checks++;
      if (got[i] !== 8'(8'h11 + i)) begin
        errors++;
        $display("FAIL drain_order[%0d]: sum=%h, required %h", i, got[i], 8'(8'h11 + i));
      end
      if (i > 0) begin
        checks++;
        if (when[i] !== when[i-1] + 1) begin
          errors++;
          $display("FAIL drain_rate[%0d]: cycle %0d after %0d, required consecutive", i, when[i], when[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] s; logic c, o; int lat;
    @(negedge clk);
    orr[0] = 1'b0; iv[0] = 1'b1; a_v[0] = 32'h20; b_v[0] = 32'h01; ci[0] = 1'b0; sb[0] = 1'b0;
    @(negedge clk);
    a_v[0] = 32'h30;
    @(negedge clk);
    iv[0] = 1'b0;
    checks++;
    if (ov[0] !== 1'b1 || sum0 !== 8'h21) begin
      errors++;
      $display("FAIL inflight_setup: valid=%b sum=%h, required valid=1 sum=21", ov[0], sum0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ov[0], co[0], of[0], ir[0]} !== 4'b0000 || sum0 !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: valid/cout/ovf/ready=%b%b%b%b sum=%h, required 0000 sum=00",
               ov[0], co[0], of[0], ir[0], sum0);
    end
    @(negedge clk);
    rst = 1'b0; orr[0] = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_empty: valid=%b ready=%b, required valid=0 ready=1", ov[0], ir[0]);
    end
    drive_single(8'h03, 8'h04, 1'b0, 1'b0, s, c, o, lat);
    checks++;
    if (s !== 8'h07 || lat !== 2) begin
      errors++;
      $display("FAIL post_reset_first: sum=%h latency=%0d, required sum=07 latency=2", s, lat);
    end
  endtask

  task automatic test_sweep(input int d, input int w);
    logic [33:0] q [$];
    logic [33:0] exp_v, got_v, prev_v;
    logic prev_hold;
    int outs, guard;
    outs = 0; prev_hold = 1'b0; prev_v = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if ({of[d], co[d], sum_of(d)} !== prev_v) begin
          errors++;
          $display("FAIL sweep_stable dut%0d: %h changed from %h while stalled", d,
                   {of[d], co[d], sum_of(d)}, prev_v);
        end
      end
      iv[d]  = ($urandom_range(0, 3) != 0);
      orr[d] = ($urandom_range(0, 2) != 0);
      a_v[d] = $urandom; b_v[d] = $urandom;
      ci[d]  = 1'($urandom_range(0, 1)); sb[d] = 1'($urandom_range(0, 1));
      #1;
      if (ov[d] && orr[d]) begin
        checks++;
        got_v = {of[d], co[d], sum_of(d)};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sweep_spurious dut%0d: output %h with nothing in flight", d, got_v);
        end else begin
          exp_v = q.pop_front();
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL sweep_result dut%0d: ovf/cout/sum=%h, required %h", d, got_v, exp_v);
          end
        end
        outs++;
      end
      if (iv[d] && ir[d]) q.push_back(ref_model(w, a_v[d], b_v[d], ci[d], sb[d]));
      prev_hold = ov[d] && !orr[d];
      prev_v    = {of[d], co[d], sum_of(d)};
    end
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      iv[d] = 1'b0; orr[d] = 1'b1;
      #1;
      if (ov[d]) begin
        checks++;
        exp_v = q.pop_front();
        got_v = {of[d], co[d], sum_of(d)};
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL sweep_drain dut%0d: ovf/cout/sum=%h, required %h", d, got_v, exp_v);
        end
        outs++;
      end
      guard++;
    end
    checks++;
    if (q.size() != 0 || outs < 50) begin
      errors++;
      $display("FAIL sweep_complete dut%0d: %0d left in flight, %0d delivered, required 0 left and >=50",
               d, q.size(), outs);
    end
    @(negedge clk);
    iv[d] = 1'b0; orr[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv = '0; orr = '0; ci = '0; sb = '0;
    for (int d = 0; d < 4; d++) begin
      a_v[d] = '0; b_v[d] = '0;
    end
    test_reset();
    test_add();
    test_sub();
    test_back_pressure();
    test_reset_mid();
    test_sweep(1, 8);
    test_sweep(2, 8);
    test_sweep(3, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor built from chained single-bit full-adder cells. The WIDTH-bit operands are split into STAGES equal slices. Each pipeline stage adds one slice and registers the carry into the next, so the block closes timing at any width. A valid/ready handshake on both sides gives full throughput (one result per cycle) with back-pressure. The block sits in the arithmetic datapath as the drop-in replacement for hand-chained full-adder cells.

## Interface
- WIDTH, 8, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages; each stage adds WIDTH/STAGES bits; range 1..WIDTH.
- CLK  in  1  the single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- IN_VALID  in  1  operand bundle presented.
- IN_READY  out  1  block accepts the bundle this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- CIN  in  1  carry-in; used in add mode only.
- SUB  in  1  mode: 0 computes A+B+CIN, 1 computes A−B (A+~B+1, CIN ignored).
- OUT_VALID  out  1  result bundle valid.
- OUT_READY  in  1  downstream accepts the result.
- SUM  out  WIDTH  result, modulo 2^WIDTH.
- COUT  out  1  carry-out of the MSB. In subtract mode, 1 means no borrow.
- OVF  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- **Transfers.** An input transfer occurs when IN_VALID && IN_READY. An output transfer occurs when OUT_VALID && OUT_READY.
- **Stage 0.** On input transfer, stage 0 captures:
  - B' = SUB ? ~B : B
  - c0 = SUB ? 1 : CIN
  - the slice-0 sum and carry of A + B' + c0
  - the unprocessed upper slices of A and B'
- **Stage k.** Stage k adds slice k using the registered carry from stage k−1. It forwards already-computed lower sum slices (de-skew) and the remaining upper operand slices (skew).
- **Flags.** The last stage registers SUM, COUT and OVF. OVF uses the carry into bit WIDTH−1, which is internal to the final slice.
- **Stage valids.** Each stage holds a valid bit. Stage k loads when it is empty or when its contents move on in the same cycle (bubble-collapsing).
  - IN_READY = !v[0] || advance[0], where advance[k] = (k = last) ? OUT_READY : (!v[k+1] || advance[k+1]).
  - IN_READY is combinational from OUT_READY and stage valids, with no dependence on IN_VALID.
- **Output stability.** SUM, COUT and OVF are stable while OUT_VALID && !OUT_READY.
- **Ordering.** Results leave in acceptance order. No drop, no duplicate.

## Timing
- **Reset.** While RST is high:
  - all stage valids = 0 and all data registers = 0
  - OUT_VALID = 0, SUM = 0, COUT = 0, OVF = 0
  - IN_READY = 0
- **After reset.** IN_READY = 1 from the first cycle after RST deasserts.
- **Latency.** STAGES cycles from input transfer to OUT_VALID when unstalled. STAGES = 1 gives a single registered adder with 1-cycle latency.
- **Throughput.** One transfer per cycle with OUT_READY held high. Simultaneous input and output transfer when full is legal and keeps occupancy constant.
- **Capacity.** Up to STAGES results in flight. When all stages are valid and OUT_READY = 0, IN_READY = 0.
- **Bubbles.** A bubble at stage k is filled in the same cycle that stage k−1 holds valid data, even while the output is stalled.
- **Reset mid-operation.** Reset discards all in-flight results. No output transfer occurs for them, and OUT_VALID drops asynchronously with RST.
- **Unused inputs.** CIN is ignored when SUB = 1. A, B, CIN and SUB are ignored when no input transfer occurs.

## Structure
- **Shared arithmetic package:**
  - slice width constant SLICE = WIDTH/STAGES
  - mode encoding constants ADD = 0, SUB = 1
  - elaboration check that WIDTH % STAGES == 0
- **Sub-module `fa_cell`:** one-bit full adder, inputs x, y, ci and outputs s, co (s = x^y^ci, co = majority). It is instantiated SLICE times per stage in a generate ripple chain.
- **Top level:** owns stage registers, skew/de-skew registers and the valid/ready chain.

## Test plan
- **Add, signed overflow.** WIDTH = 8, STAGES = 2; A = 0x7F, B = 0x01, CIN = 0, SUB = 0 -> after 2 cycles SUM = 0x80, COUT = 0, OVF = 1.
- **Add, unsigned wrap.** A = 0xFF, B = 0x01, CIN = 0 -> SUM = 0x00, COUT = 1, OVF = 0. Same operands with CIN = 1 -> SUM = 0x01, COUT = 1.
- **Subtract.**
  - A = 0x00, B = 0x01, SUB = 1, CIN = 1 (must be ignored) -> SUM = 0xFF, COUT = 0, OVF = 0.
  - A = 0x80, B = 0x01, SUB = 1 -> SUM = 0x7F, COUT = 1, OVF = 1.
- **Back-pressure.** 5 back-to-back bundles (A = 1..5, B = 0x10) with OUT_READY = 0 for 6 cycles:
  - IN_READY falls after 2 accepts
  - SUM holds 0x11 stable
  - after release, outputs 0x11..0x15 appear in order, one per cycle, with no loss
- **Reset mid-stream.** Assert RST asynchronously while 2 results are in flight -> OUT_VALID and SUM go to 0 immediately. The first post-reset input (0x03 + 0x04) yields SUM = 0x07 after exactly 2 cycles.
- **Parameter sweep.** Random regression for (WIDTH, STAGES) in {(8,1), (8,8), (32,4)} with random valid/ready -> every output equals the reference model (A ± B + c) mod 2^WIDTH with correct COUT and OVF.
